vga_pixel_stream: RTL and testbench



---
 rtl/vga_pixel_stream.sv | 135 +++++++++++++
 tb/tb_vga_pixel_stream.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_stream.sv
// VGA timing generator and pixel streamer: reads RGB565 words from the display FIFO one cycle
// ahead of each active pixel and blanks to the next frame boundary on FIFO underflow.
module vga_pixel_stream #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        empty_fifo,
    input  logic [15:0] din,
    output logic        rd_en,
    output logic [4:0]  vga_out_r,
    output logic [5:0]  vga_out_g,
    output logic [4:0]  vga_out_b,
    output logic        vga_out_hs,
    output logic        vga_out_vs,
    output logic        vga_out_bl,
    output logic        vga_out_sy,
    output logic        frame_start,
    output logic [7:0]  underflow_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] HActive    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HSyncStart = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HSyncEnd   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] VActive    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VSyncStart = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VSyncEnd   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);

    typedef enum logic [0:0] {StWaitSync, StStream} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]    ucnt_q, ucnt_d;

    // Stage 1: decode flags delayed by one cycle, aligned with din
    logic act1_q, hs1_q, vs1_q, rd1_q, fs1_q;
    // Stage 2: pin registers
    logic [15:0] rgb_q, rgb_d;
    logic        hs_q, vs_q, bl_q, fs_q;

    logic h_last, v_last, active, hs_dec, vs_dec, underflow, frame_first;

    always_comb begin
        h_last      = (h_cnt_q == HLast);
        v_last      = (v_cnt_q == VLast);
        active      = (h_cnt_q < HActive) && (v_cnt_q < VActive);
        hs_dec      = !((h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd));
        vs_dec      = !((v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd));
        rd_en       = (state_q == StStream) && active && !empty_fifo;
        underflow   = (state_q == StStream) && active && empty_fifo;
        frame_first = rd_en && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_comb begin
        h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end

        state_d = state_q;
        unique case (state_q)
            StWaitSync: if (h_last && v_last && !empty_fifo) state_d = StStream;
            StStream:   if (underflow) state_d = StWaitSync;
            default:    state_d = StWaitSync;
        endcase

        ucnt_d = ucnt_q;
        if (underflow && (ucnt_q != 8'hFF)) begin
            ucnt_d = ucnt_q + 8'd1;
        end

        rgb_d = rd1_q ? din : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWaitSync;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            ucnt_q  <= 8'd0;
            act1_q  <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            rd1_q   <= 1'b0;
            fs1_q   <= 1'b0;
            rgb_q   <= 16'h0000;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            bl_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            ucnt_q  <= ucnt_d;
            act1_q  <= active;
            hs1_q   <= hs_dec;
            vs1_q   <= vs_dec;
            rd1_q   <= rd_en;
            fs1_q   <= frame_first;
            rgb_q   <= rgb_d;
            hs_q    <= hs1_q;
            vs_q    <= vs1_q;
            bl_q    <= act1_q;
            fs_q    <= fs1_q;
        end
    end

    assign vga_out_r     = rgb_q[15:11];
    assign vga_out_g     = rgb_q[10:5];
    assign vga_out_b     = rgb_q[4:0];
    assign vga_out_hs    = hs_q;
    assign vga_out_vs    = vs_q;
    assign vga_out_bl    = bl_q;
    assign vga_out_sy    = 1'b0;
    assign frame_start   = fs_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Bench for vga_pixel_stream on a shrunken raster, checked cycle by cycle against a
// frame-position model derived from the elapsed cycle count.
module tb_vga_pixel_stream;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        empty_fifo = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        rd_en;
    logic [4:0]  vga_out_r;
    logic [5:0]  vga_out_g;
    logic [4:0]  vga_out_b;
    logic        vga_out_hs, vga_out_vs, vga_out_bl, vga_out_sy, frame_start;
    logic [7:0]  underflow_cnt;

    vga_pixel_stream #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .empty_fifo   (empty_fifo),
        .din          (din),
        .rd_en        (rd_en),
        .vga_out_r    (vga_out_r),
        .vga_out_g    (vga_out_g),
        .vga_out_b    (vga_out_b),
        .vga_out_hs   (vga_out_hs),
        .vga_out_vs   (vga_out_vs),
        .vga_out_bl   (vga_out_bl),
        .vga_out_sy   (vga_out_sy),
        .frame_start  (frame_start),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position from elapsed cycles, streaming flag, and 2-deep output history
    int          k;
    bit          streaming;
    int          ucnt;
    bit          rd_h[2], act_h[2], hs_h[2], vs_h[2], fs_h[2];
    logic [15:0] din_prev;
    int          first_rd, obs_rd, obs_fs, obs_hs_low;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0; streaming = 0; ucnt = 0; din_prev = 16'h0000; first_rd = -1;
        for (int i = 0; i < 2; i++) begin
            rd_h[i] = 0; act_h[i] = 0; hs_h[i] = 1; vs_h[i] = 1; fs_h[i] = 0;
        end
    endtask

    task automatic clear_obs();
        obs_rd = 0; obs_fs = 0; obs_hs_low = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, {15'd0, rd_en}, 16'd0);
        chk({tag, "_rgb"}, {vga_out_r, vga_out_g, vga_out_b}, 16'd0);
        chk({tag, "_hs"}, {15'd0, vga_out_hs}, 16'd1);
        chk({tag, "_vs"}, {15'd0, vga_out_vs}, 16'd1);
        chk({tag, "_bl"}, {15'd0, vga_out_bl}, 16'd0);
        chk({tag, "_sy"}, {15'd0, vga_out_sy}, 16'd0);
        chk({tag, "_fs"}, {15'd0, frame_start}, 16'd0);
        chk({tag, "_ucnt"}, {8'd0, underflow_cnt}, 16'd0);
    endtask

    // One pixel clock: drive inputs at negedge, check all outputs, advance the model
    task automatic cycle(input bit e);
        int h, v;
        bit act, rd, hsd, vsd, fs, under;
        logic [15:0] exp_rgb;
        empty_fifo = e;
        din = 16'($urandom);
        #1;
        h = k % HT;
        v = (k / HT) % VT;
        act = (h < HA) && (v < VA);
        rd = streaming && act && !e;
        under = streaming && act && e;
        hsd = !((h >= HA + HF) && (h < HA + HF + HS));
        vsd = !((v >= VA + VF) && (v < VA + VF + VS));
        fs = rd && (h == 0) && (v == 0);
        exp_rgb = rd_h[1] ? din_prev : 16'h0000;

        chk("rd_en", {15'd0, rd_en}, {15'd0, rd});
        chk("rgb", {vga_out_r, vga_out_g, vga_out_b}, exp_rgb);
        chk("hs", {15'd0, vga_out_hs}, {15'd0, hs_h[1]});
        chk("vs", {15'd0, vga_out_vs}, {15'd0, vs_h[1]});
        chk("bl", {15'd0, vga_out_bl}, {15'd0, act_h[1]});
        chk("sy", {15'd0, vga_out_sy}, 16'd0);
        chk("frame_start", {15'd0, frame_start}, {15'd0, fs_h[1]});
        chk("underflow_cnt", {8'd0, underflow_cnt}, 16'(ucnt));

        if (rd_en && first_rd < 0) first_rd = k;
        obs_rd += int'(rd_en);
        obs_fs += int'(frame_start);
        obs_hs_low += int'(!vga_out_hs);

        rd_h[1] = rd_h[0];   rd_h[0] = rd;
        act_h[1] = act_h[0]; act_h[0] = act;
        hs_h[1] = hs_h[0];   hs_h[0] = hsd;
        vs_h[1] = vs_h[0];   vs_h[0] = vsd;
        fs_h[1] = fs_h[0];   fs_h[0] = fs;
        din_prev = din;
        if (under) begin
            streaming = 0;
            if (ucnt < 255) ucnt++;
        end else if (!streaming && h == HT - 1 && v == VT - 1 && !e) begin
            streaming = 1;
        end
        k++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        clear_obs();
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Always non-empty: frame 1 waits, frame 2 streams every active pixel
        for (int i = 0; i < FRAME; i++) cycle(1'b0);
        chk("frame1_rd_count", 16'(obs_rd), 16'd0);
        clear_obs();
        for (int i = 0; i < FRAME; i++) cycle(1'b0);
        chk("frame2_rd_count", 16'(obs_rd), 16'(HA * VA));
        chk("frame2_fs_count", 16'(obs_fs), 16'd1);
        chk("frame2_hs_low", 16'(obs_hs_low), 16'(HS * VT));
        chk("first_rd_cycle", 16'(first_rd), 16'(FRAME));

        // Empty at the first frame end: streaming begins one frame later
        apply_reset();
        for (int i = 0; i < FRAME; i++) cycle(1'b1);
        for (int i = 0; i < 2 * FRAME; i++) cycle(1'b0);
        chk("late_first_rd", 16'(first_rd), 16'(2 * FRAME));
        chk("late_ucnt", {8'd0, underflow_cnt}, 16'd0);

        // Single-cycle underflow at pixel (3,2)
        for (int i = 0; i < FRAME; i++) cycle(i == 2 * HT + 3);
        chk("single_uf_ucnt", {8'd0, underflow_cnt}, 16'd1);
        clear_obs();
        for (int i = 0; i < FRAME; i++) cycle(1'b0);
        chk("resume_rd_count", 16'(obs_rd), 16'(HA * VA));

        // Random FIFO emptiness
        for (int i = 0; i < 6 * FRAME; i++) cycle(($urandom % 8) == 0);

        // Underflow at (0,0) of every frame, refilled by frame end: saturates the counter
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < FRAME; i++) cycle(i == 0);
        end
        chk("ucnt_saturated", {8'd0, underflow_cnt}, 16'd255);

        // Asynchronous reset mid-line at pixel (4,2) while streaming
        for (int i = 0; i < 2 * HT + 4; i++) cycle(1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) cycle(1'b0);
        chk("post_reset_first_rd", 16'(first_rd), 16'(FRAME));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
